reg_file_32x64: RTL

- 32-entry × 64-bit register file: two combinational read ports, one clocked write port.
- Consumes the one-hot write-enable vector produced by a tree of enabled 1-to-2 decoders; each decoder output gates exactly one register row.
- Register 31 is the hardwired zero register (XZR).
- Sits between instruction decode and the ALU in the single-cycle datapath.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/write_decoder5_32.sv | 47 ++++
 rtl/reg_file_32x64.sv | 83 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 32 x 64-bit register file.
//
// Contents:
//   DATA_W, ADDR_W, NUM_REGS, ZERO_REG  - geometry of the register file
//   reg_addr_t, reg_data_t              - register index and register data types
//   ZERO_ADDR                           - ZERO_REG as a reg_addr_t, for width-exact compares
//   dec1to2()                           - enabled 1-to-2 decoder, the only decode primitive
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

  // Enabled 1-to-2 decoder: bit 1 follows en when s=1, bit 0 follows en when s=0.
  function automatic logic [1:0] dec1to2(input logic en, input logic s);
    logic [1:0] y;
    y[1] = en & s;
    y[0] = en & ~s;
    return y;
  endfunction

endpackage

// File: rtl/write_decoder5_32.sv
// 5-to-32 write-enable decoder built purely from enabled 1-to-2 decoders.
//
// The root decoder on sel[4] is enabled by en and feeds two 4-to-16 subtrees, which in turn
// split on sel[3], sel[2], sel[1] and finally sel[0] at the leaves. Node j of a level encodes
// the high-order sel bits seen so far, so child 2*j+s of node j ends up at out[sel].
//
// Ports:
//   en   in   1   root enable (register write enable)
//   sel  in   5   destination register index
//   out  out  32  one-hot when en=1, all zero when en=0
module write_decoder5_32
  import regfile_pkg::*;
(
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);

  logic [1:0]  lvl1;
  logic [3:0]  lvl2;
  logic [7:0]  lvl3;
  logic [15:0] lvl4;
  logic [31:0] lvl5;

  // Root: split on the most significant select bit.
  assign lvl1 = dec1to2(en, sel[4]);

  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    assign lvl2[2*i +: 2] = dec1to2(lvl1[i], sel[3]);
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl3
    assign lvl3[2*i +: 2] = dec1to2(lvl2[i], sel[2]);
  end

  for (genvar i = 0; i < 8; i++) begin : g_lvl4
    assign lvl4[2*i +: 2] = dec1to2(lvl3[i], sel[1]);
  end

  // Leaves: split on the least significant select bit.
  for (genvar i = 0; i < 16; i++) begin : g_lvl5
    assign lvl5[2*i +: 2] = dec1to2(lvl4[i], sel[0]);
  end

  assign out = lvl5;

endmodule

// File: rtl/reg_file_32x64.sv
// 32-entry x 64-bit register file with two combinational read ports and one clocked write port.
// Register ZERO_REG (x31) has no storage: it always reads zero and writes to it are dropped.
//
// Ports:
//   clk        in   1       rising-edge clock for all state
//   reset      in   1       synchronous active-high clear of every row; wins over a write
//   reg_write  in   1       write enable (root enable of the write decoder)
//   wr_addr    in   ADDR_W  destination register index
//   wr_data    in   DATA_W  write data
//   rd_addr1   in   ADDR_W  read port 1 index
//   rd_addr2   in   ADDR_W  read port 2 index
//   rd_data1   out  DATA_W  read port 1 data (zero for ZERO_REG)
//   rd_data2   out  DATA_W  read port 2 data (zero for ZERO_REG)
//
// Reads are not bypassed: a read of the row being written returns the old value until the edge.
module reg_file_32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [NUM_REGS-1:0] wr_en;
  reg_data_t           rows [NUM_REGS];

  write_decoder5_32 u_write_decoder (
    .en  (reg_write),
    .sel (wr_addr),
    .out (wr_en)
  );

  // Row bank: each row loads only on its own decoder bit, so unselected rows hold.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    if (i == ZERO_REG) begin : g_zero
      assign rows[i] = '0;
    end else begin : g_store
      reg_data_t row_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          row_q <= '0;
        end else if (wr_en[i]) begin
          row_q <= wr_data;
        end
      end

      assign rows[i] = row_q;
    end
  end

  // The decoder bit for the zero register has nothing to load.
  logic unused_zero_wr;
  assign unused_zero_wr = wr_en[ZERO_REG];

  // Read muxes; the zero-register override is explicit so x31 never depends on the bank.
  always_comb begin
    rd_data1 = rows[rd_addr1];
    if (rd_addr1 == ZERO_ADDR) begin
      rd_data1 = '0;
    end
  end

  always_comb begin
    rd_data2 = rows[rd_addr2];
    if (rd_addr2 == ZERO_ADDR) begin
      rd_data2 = '0;
    end
  end

  // Decoder contract: one-hot under a known write, silent otherwise.
  a_wr_onehot: assert property (@(posedge clk)
    (reg_write === 1'b1) && !$isunknown(wr_addr) |-> $onehot(wr_en));
  a_wr_idle: assert property (@(posedge clk)
    (reg_write === 1'b0) |-> (wr_en == '0));

endmodule
